// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and sizes for the shift-and-add multiplier
//
// Purpose: operand width, iteration counter width, controller state
//          encoding and the product type used by shift_add_mult_ctrl.
// Ports:   none (package).
package mult_pkg;

  localparam int WIDTH = 16;
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} mult_state_t;

  typedef logic [2*WIDTH-1:0] prod_t;

endpackage

// File: rtl/shift_add_mult_ctrl_add4bits.sv
// rtl/shift_add_mult_ctrl_add4bits.sv - 16-bit ripple-carry adder (Add4bits)
//
// Purpose: the existing 16-bit ripple-carry adder, reused as the single
//          datapath adder of the sequential multiplier.
// Ports:   a, b  16-bit addends
//          cin   carry in
//          s     16-bit sum
//          cout  carry out of bit 15
module Add4bits (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] s,
  output logic        cout
);

  logic carry;

  // The carry is a procedural temporary so the chain ripples bit by bit
  // without creating a combinational loop through a vector.
  always_comb begin
    s     = '0;
    carry = cin;
    for (int i = 0; i < 16; i++) begin
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// rtl/shift_add_mult_ctrl.sv - sequential unsigned 16x16 shift-and-add multiplier
//
// Purpose: accepts an operand pair on a valid/ready handshake, runs 16
//          shift-and-add iterations through one Add4bits instance and
//          presents the registered 32-bit product on a valid/ready handshake.
// Ports:   clk          rising-edge clock
//          rst          asynchronous active-high reset
//          start_valid  operand pair offered
//          start_ready  operands accepted (high only in IDLE)
//          a, b         multiplicand / multiplier, sampled on start handshake
//          busy         high while an operation is in RUN or DONE
//          prod_valid   product available
//          prod_ready   sink accepts product
//          prod         registered product a*b
module shift_add_mult_ctrl #(
  parameter int WIDTH = mult_pkg::WIDTH,
  parameter int CNT_W = mult_pkg::CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               prod_valid,
  input  logic               prod_ready,
  output logic [2*WIDTH-1:0] prod
);

  import mult_pkg::*;

  // The adder is hard-wired to 16 bits, so no other width can work.
  if (WIDTH != 16) begin : g_bad_width
    $error("shift_add_mult_ctrl: WIDTH must be 16");
  end
  if (CNT_W != $clog2(WIDTH) + 1) begin : g_bad_cnt_w
    $error("shift_add_mult_ctrl: CNT_W must be $clog2(WIDTH)+1");
  end

  mult_state_t      state;
  mult_state_t      state_nxt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic [CNT_W-1:0] count;
  logic             last_iter;

  // acc_lo starts as the multiplier and is consumed LSB first while the
  // low product bits shift in from the top.
  assign addend    = acc_lo[0] ? mcand : '0;
  assign last_iter = (count == CNT_W'(WIDTH - 1));

  Add4bits u_adder (
    .a    (acc_hi),
    .b    (addend),
    .cin  (1'b0),
    .s    (sum),
    .cout (cout)
  );

  assign start_ready = (state == IDLE);
  assign busy        = (state != IDLE);
  assign prod_valid  = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_valid) state_nxt = RUN;
      RUN:     if (last_iter)   state_nxt = DONE;
      DONE:    if (prod_ready)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      count  <= '0;
      prod   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            mcand  <= a;
            acc_hi <= '0;
            acc_lo <= b;
            count  <= '0;
          end
        end
        RUN: begin
          // Adder carry becomes the new MSB so no product bit is lost.
          acc_hi <= {cout, sum[WIDTH-1:1]};
          acc_lo <= {sum[0], acc_lo[WIDTH-1:1]};
          count  <= count + CNT_W'(1);
          // Capture the final accumulator directly so prod is already
          // stable on the first DONE cycle and is held afterwards.
          if (last_iter) begin
            prod <= {cout, sum, acc_lo[WIDTH-1:1]};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// tb/tb_shift_add_mult_ctrl.sv - scoreboard bench for shift_add_mult_ctrl
module tb_shift_add_mult_ctrl;

  localparam int LAT_CYC = 17;
  localparam int B2B_CYC = 18;

  logic        clk;
  logic        rst;
  logic        start_valid;
  logic        start_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        prod_valid;
  logic        prod_ready;
  logic [31:0] prod;

  shift_add_mult_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .prod_valid  (prod_valid),
    .prod_ready  (prod_ready),
    .prod        (prod)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          n_acc    = 0;
  int          prev_acc = 0;
  bit          have_prev = 0;
  bit          b2b      = 0;
  bit          rand_mode = 0;
  bit          front_seen = 0;
  logic [31:0] exp_q[$];
  int          acc_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Monitor: samples mid-cycle, where DUT outputs and bench inputs both
  // describe what the next rising edge will see.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      chk("busy", 64'(busy), 64'(exp_q.size() != 0));
      chk("start_ready", 64'(start_ready), 64'(exp_q.size() == 0));
      if (prod_valid) begin
        if (exp_q.size() == 0) begin
          flag("unexpected prod_valid");
        end else begin
          chk("prod", 64'(prod), 64'(exp_q[0]));
          if (!front_seen) begin
            chk("latency", 64'(cyc - acc_q[0]), 64'(LAT_CYC));
            front_seen = 1;
          end
          if (prod_ready) begin
            void'(exp_q.pop_front());
            void'(acc_q.pop_front());
            front_seen = 0;
          end
        end
      end else if (exp_q.size() != 0 && (cyc - acc_q[0]) >= LAT_CYC) begin
        flag("prod_valid late");
        void'(exp_q.pop_front());
        void'(acc_q.pop_front());
        front_seen = 0;
      end
      if (start_valid && start_ready) begin
        exp_q.push_back(32'(a) * 32'(b));
        acc_q.push_back(cyc);
        if (b2b && have_prev) chk("b2b interval", 64'(cyc - prev_acc), 64'(B2B_CYC));
        prev_acc  = cyc;
        have_prev = 1;
        n_acc++;
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (rand_mode) begin
      start_valid = ($urandom_range(0, 1) == 1);
      a           = 16'($urandom);
      b           = 16'($urandom);
      prod_ready  = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic issue(input logic [15:0] aa, input logic [15:0] bb);
    bit ok = 0;
    int n  = 0;
    @(posedge clk); #2;
    a = aa; b = bb; start_valid = 1'b1;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = start_ready;
      @(posedge clk); #2;
      n++;
    end
    start_valid = 1'b0;
    if (!ok) flag("start handshake timeout");
  endtask

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) flag("drain timeout");
    @(posedge clk); #2;
  endtask

  initial begin
    rst = 1'b0; start_valid = 1'b0; prod_ready = 1'b0; a = '0; b = '0;
    #1 rst = 1'b1;
    #1;
    chk("reset prod_valid", 64'(prod_valid), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset prod", 64'(prod), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1 chk("start_ready after reset", 64'(start_ready), 64'd1);

    // Basic, carry-heavy and zero operands
    prod_ready = 1'b1;
    issue(16'd3, 16'd5);
    wait_idle(100);
    issue(16'hFFFF, 16'hFFFF);
    wait_idle(100);
    issue(16'h0000, 16'h1234);
    wait_idle(100);

    // Backpressure: held product, start offers ignored
    prod_ready = 1'b0;
    issue(16'h1234, 16'h0010);
    begin
      int n = 0;
      while (!prod_valid && n < 100) begin @(posedge clk); #2; n++; end
      if (!prod_valid) flag("backpressure prod_valid timeout");
    end
    chk("backpressure prod", 64'(prod), 64'h12340);
    start_valid = 1'b1; a = 16'hBEEF; b = 16'h0101;
    repeat (5) @(posedge clk);
    #2 start_valid = 1'b0; prod_ready = 1'b1;
    wait_idle(100);

    // Back-to-back stream
    b2b = 1; have_prev = 0;
    begin
      int base = n_acc;
      int n = 0;
      start_valid = 1'b1;
      while (n_acc < base + 8 && n < 400) begin
        a = 16'($urandom); b = 16'($urandom);
        @(posedge clk); #2;
        n++;
      end
      start_valid = 1'b0;
      if (n_acc < base + 8) flag("b2b stream timeout");
    end
    wait_idle(100);
    b2b = 0;

    // Asynchronous reset in the middle of RUN
    issue(16'hABCD, 16'h1357);
    repeat (8) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrun rst busy", 64'(busy), 64'd0);
    chk("midrun rst prod_valid", 64'(prod_valid), 64'd0);
    chk("midrun rst prod", 64'(prod), 64'd0);
    chk("midrun rst start_ready", 64'(start_ready), 64'd1);
    exp_q.delete();
    acc_q.delete();
    front_seen = 0;
    @(posedge clk); #2 rst = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    issue(16'd7, 16'd9);
    wait_idle(100);

    // Random operands with random stalls
    begin
      int base = n_acc;
      int n = 0;
      rand_mode = 1;
      while (n_acc < base + 1000 && n < 60000) begin
        @(posedge clk);
        n++;
      end
      #3;
      rand_mode = 0;
      start_valid = 1'b0;
      prod_ready = 1'b1;
      if (n_acc < base + 1000) flag("random run timeout");
    end
    wait_idle(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
